run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run/halt sequencer for a small core.
//
// A start request moves the block from IDLE (or HALT) through an optional
// DELAY phase into RUN, where the core PC is enabled. RUN cycles and
// nonzero-instruction cycles are counted. The run ends in HALT on an external
// stop, on ZERO_RUN consecutive zero instructions (armed only after MIN_RUN
// RUN cycles), or when the RUN-cycle limit TIMEOUT is reached.
//
// Ports
//   clk        : clock, rising edge
//   rst_       : asynchronous active-low reset
//   start      : run request (honoured in IDLE and HALT)
//   stop       : external halt request (honoured in DELAY and RUN)
//   inst       : current fetched instruction
//   ena_pc     : PC/core enable, high in RUN
//   halted     : high in HALT
//   halt_cause : 00 none, 01 zero inst, 10 timeout, 11 external stop
//   state      : 00 IDLE, 01 DELAY, 10 RUN, 11 HALT
//   cycle_cnt  : RUN cycles elapsed (saturating)
//   inst_cnt   : RUN cycles with a nonzero inst (saturating)
module run_ctrl #(
    parameter int INST_W    = 32,
    parameter int CNT_W     = 32,
    parameter int START_DLY = 1,
    parameter int MIN_RUN   = 3,
    parameter int ZERO_RUN  = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              stop,
    input  logic [INST_W-1:0] inst,
    output logic              ena_pc,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);

    localparam int DLY_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
    localparam int ZR_W  = $clog2(ZERO_RUN + 1);

    localparam logic [DLY_W-1:0] START_DLY_C = DLY_W'(START_DLY);
    localparam logic [DLY_W-1:0] DLY_ONE     = DLY_W'(1);
    localparam logic [CNT_W-1:0] MIN_RUN_C   = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    // One extra bit so cycle_cnt+1 never wraps before the compare.
    localparam logic [CNT_W:0]   TIMEOUT_C   = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0]   CNT_ONE_X   = (CNT_W + 1)'(1);
    localparam logic [ZR_W:0]    ZERO_RUN_C  = (ZR_W + 1)'(ZERO_RUN);
    localparam logic [ZR_W:0]    ZR_ONE_X    = (ZR_W + 1)'(1);

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_ZERO = 2'b01;
    localparam logic [1:0] C_TMO  = 2'b10;
    localparam logic [1:0] C_STOP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DELAY = 2'b01,
        S_RUN   = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [ZR_W-1:0]    zrun_q, zrun_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ins_q, ins_d;
    logic               ena_q, halted_q;

    logic               inst_zero;
    logic               armed;
    logic [ZR_W:0]      zrun_inc;
    logic               zero_hit;
    logic               tmo_hit;

    // Halt conditions use the pre-increment counter values of this cycle.
    assign inst_zero = (inst == '0);
    assign armed     = (cyc_q >= MIN_RUN_C);
    assign zrun_inc  = {1'b0, zrun_q} + ZR_ONE_X;
    assign zero_hit  = armed && inst_zero && (zrun_inc == ZERO_RUN_C);
    assign tmo_hit   = (TIMEOUT != 0) && (({1'b0, cyc_q} + CNT_ONE_X) == TIMEOUT_C);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        zrun_d  = zrun_q;
        cause_d = cause_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    cyc_d   = '0;
                    ins_d   = '0;
                    zrun_d  = '0;
                    cause_d = C_NONE;
                    dly_d   = START_DLY_C;
                    state_d = (START_DLY == 0) ? S_RUN : S_DELAY;
                end
            end
            S_DELAY: begin
                if (stop) begin
                    state_d = S_HALT;
                    cause_d = C_STOP;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q - DLY_ONE;
                    if (dly_q <= DLY_ONE) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Counters advance in the halting cycle too.
                if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_ONE;
                if (!inst_zero && ins_q != CNT_MAX) ins_d = ins_q + CNT_ONE;
                if (armed && inst_zero) zrun_d = zrun_inc[ZR_W-1:0];
                else                    zrun_d = '0;

                if (stop) begin
                    state_d = S_HALT;
                    cause_d = C_STOP;
                end else if (zero_hit) begin
                    state_d = S_HALT;
                    cause_d = C_ZERO;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    cause_d = C_TMO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            dly_q    <= '0;
            zrun_q   <= '0;
            cause_q  <= C_NONE;
            cyc_q    <= '0;
            ins_q    <= '0;
            ena_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            zrun_q   <= zrun_d;
            cause_q  <= cause_d;
            cyc_q    <= cyc_d;
            ins_q    <= ins_d;
            ena_q    <= (state_d == S_RUN);
            halted_q <= (state_d == S_HALT);
        end
    end

    assign ena_pc     = ena_q;
    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign state      = state_q;
    assign cycle_cnt  = cyc_q;
    assign inst_cnt   = ins_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: four parameter sets share one stimulus stream.
//   u0 defaults, u1 ZERO_RUN=3, u2 TIMEOUT=10,
//   u3 START_DLY=0 MIN_RUN=2 ZERO_RUN=2 CNT_W=4 INST_W=8.
module tb_run_ctrl;

    logic        clk   = 1'b0;
    logic        rst_  = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [31:0] inst  = '0;

    always #5 clk = ~clk;

    logic        ena0, ena1, ena2, ena3;
    logic        hlt0, hlt1, hlt2, hlt3;
    logic [1:0]  cau0, cau1, cau2, cau3;
    logic [1:0]  st0, st1, st2, st3;
    logic [31:0] cyc0, cyc1, cyc2, ins0, ins1, ins2;
    logic [3:0]  cyc3, ins3;

    run_ctrl u0 (.clk(clk), .rst_(rst_), .start(start), .stop(stop), .inst(inst),
        .ena_pc(ena0), .halted(hlt0), .halt_cause(cau0), .state(st0),
        .cycle_cnt(cyc0), .inst_cnt(ins0));
    run_ctrl #(.ZERO_RUN(3)) u1 (.clk(clk), .rst_(rst_), .start(start), .stop(stop),
        .inst(inst), .ena_pc(ena1), .halted(hlt1), .halt_cause(cau1), .state(st1),
        .cycle_cnt(cyc1), .inst_cnt(ins1));
    run_ctrl #(.TIMEOUT(10)) u2 (.clk(clk), .rst_(rst_), .start(start), .stop(stop),
        .inst(inst), .ena_pc(ena2), .halted(hlt2), .halt_cause(cau2), .state(st2),
        .cycle_cnt(cyc2), .inst_cnt(ins2));
    run_ctrl #(.INST_W(8), .CNT_W(4), .START_DLY(0), .MIN_RUN(2), .ZERO_RUN(2)) u3 (
        .clk(clk), .rst_(rst_), .start(start), .stop(stop), .inst(inst[7:0]),
        .ena_pc(ena3), .halted(hlt3), .halt_cause(cau3), .state(st3),
        .cycle_cnt(cyc3), .inst_cnt(ins3));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic grab(input int i, output logic [1:0] s, output logic e, output logic h,
                        output logic [1:0] c, output logic [63:0] cy, output logic [63:0] in);
        case (i)
            0: begin s = st0; e = ena0; h = hlt0; c = cau0; cy = 64'(cyc0); in = 64'(ins0); end
            1: begin s = st1; e = ena1; h = hlt1; c = cau1; cy = 64'(cyc1); in = 64'(ins1); end
            2: begin s = st2; e = ena2; h = hlt2; c = cau2; cy = 64'(cyc2); in = 64'(ins2); end
            default: begin s = st3; e = ena3; h = hlt3; c = cau3; cy = 64'(cyc3); in = 64'(ins3); end
        endcase
    endtask

    // Reference model: mode 0 idle, 1 delay, 2 run, 3 halt. The delay phase
    // is tracked as an absolute target edge; the zero detector as a count of
    // trailing zero instructions seen while armed.
    int     P_DLY[4] = '{1, 1, 1, 0};
    int     P_MIN[4] = '{3, 3, 3, 2};
    int     P_ZR[4]  = '{1, 3, 1, 2};
    int     P_TO[4]  = '{0, 0, 10, 0};
    int     P_CW[4]  = '{32, 32, 32, 4};
    int     P_IW[4]  = '{32, 32, 32, 8};

    int     m_mode[4];
    int     m_cause[4];
    int     m_zeros[4];
    longint m_cyc[4];
    longint m_ins[4];
    longint m_run_at[4];
    longint edge_no = 0;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 0; m_cause[i] = 0; m_zeros[i] = 0;
            m_cyc[i] = 0; m_ins[i] = 0; m_run_at[i] = 0;
        end
    endtask

    task automatic m_step(input int i, input logic s, input logic p, input logic [31:0] iv);
        longint maxc;
        logic [31:0] mv;
        bit iz, armed, zhit, thit;
        maxc = (longint'(1) << P_CW[i]) - 1;
        mv   = (P_IW[i] >= 32) ? iv : (iv & ((32'd1 << P_IW[i]) - 32'd1));
        iz   = (mv == 0);
        case (m_mode[i])
            0, 3: if (s) begin
                m_cyc[i] = 0; m_ins[i] = 0; m_zeros[i] = 0; m_cause[i] = 0;
                if (P_DLY[i] == 0) m_mode[i] = 2;
                else begin m_mode[i] = 1; m_run_at[i] = edge_no + P_DLY[i]; end
            end
            1: begin
                if (p) begin m_mode[i] = 3; m_cause[i] = 3; end
                else if (edge_no == m_run_at[i]) m_mode[i] = 2;
            end
            default: begin
                armed = (m_cyc[i] >= P_MIN[i]);
                m_zeros[i] = (armed && iz) ? m_zeros[i] + 1 : 0;
                zhit = armed && iz && (m_zeros[i] >= P_ZR[i]);
                thit = (P_TO[i] != 0) && (m_cyc[i] + 1 == P_TO[i]);
                if (m_cyc[i] < maxc) m_cyc[i]++;
                if (!iz && m_ins[i] < maxc) m_ins[i]++;
                if (p)         begin m_mode[i] = 3; m_cause[i] = 3; end
                else if (zhit) begin m_mode[i] = 3; m_cause[i] = 1; end
                else if (thit) begin m_mode[i] = 3; m_cause[i] = 2; end
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst_) begin
            edge_no++;
            for (int i = 0; i < 4; i++) m_step(i, start, stop, inst);
        end
    end

    // Continuous comparison of every instance against the model.
    always @(negedge clk) begin
        logic [1:0] s, c; logic e, h; logic [63:0] cy, in;
        for (int i = 0; i < 4; i++) begin
            grab(i, s, e, h, c, cy, in);
            chk($sformatf("u%0d.state", i),  64'(s), 64'(m_mode[i]));
            chk($sformatf("u%0d.ena_pc", i), 64'(e), 64'(m_mode[i] == 2));
            chk($sformatf("u%0d.halted", i), 64'(h), 64'(m_mode[i] == 3));
            chk($sformatf("u%0d.cause", i),  64'(c), 64'(m_cause[i]));
            chk($sformatf("u%0d.cyc", i),    cy,     64'(m_cyc[i]));
            chk($sformatf("u%0d.ins", i),    in,     64'(m_ins[i]));
        end
    end

    // Apply inputs for one cycle; returns 1 time unit after the edge.
    task automatic tick(input logic s, input logic p, input logic [31:0] iv);
        start = s; stop = p; inst = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_u(input int i, input string tag, input int est, input int ecause,
                            input longint ecyc, input longint eins);
        logic [1:0] s, c; logic e, h; logic [63:0] cy, in;
        grab(i, s, e, h, c, cy, in);
        chk($sformatf("%s u%0d.state", tag, i),  64'(s), 64'(est));
        chk($sformatf("%s u%0d.ena_pc", tag, i), 64'(e), 64'(est == 2));
        chk($sformatf("%s u%0d.halted", tag, i), 64'(h), 64'(est == 3));
        chk($sformatf("%s u%0d.cause", tag, i),  64'(c), 64'(ecause));
        if (ecyc >= 0) chk($sformatf("%s u%0d.cyc", tag, i), cy, 64'(ecyc));
        if (eins >= 0) chk($sformatf("%s u%0d.ins", tag, i), in, 64'(eins));
    endtask

    // Asserted between edges; outputs must clear before the next clock edge.
    task automatic do_reset();
        logic [1:0] s, c; logic e, h; logic [63:0] cy, in;
        start = 0; stop = 0;
        rst_ = 1'b0;
        m_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            grab(i, s, e, h, c, cy, in);
            chk($sformatf("rst u%0d.state", i),  64'(s), 64'd0);
            chk($sformatf("rst u%0d.ena_pc", i), 64'(e), 64'd0);
            chk($sformatf("rst u%0d.halted", i), 64'(h), 64'd0);
            chk($sformatf("rst u%0d.cause", i),  64'(c), 64'd0);
            chk($sformatf("rst u%0d.cyc", i),    cy,     64'd0);
            chk($sformatf("rst u%0d.ins", i),    in,     64'd0);
        end
        @(posedge clk);
        #3 rst_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        s;
        logic        p;
        logic [31:0] iv;
        int          est;
        int          ecause;
        longint      ecyc;
        longint      eins;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic p, input logic [31:0] iv,
                                input int est, input int ecause, input longint ecyc,
                                input longint eins);
        vec_t v;
        v.s = s; v.p = p; v.iv = iv; v.est = est; v.ecause = ecause;
        v.ecyc = ecyc; v.eins = eins;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   pat[6];

        // Default parameters: start at edge 3, five nonzero instructions, then zero.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));   // stop ignored in IDLE
        tbl.push_back(mk(1, 0, 3, 1, 0, 0, 0));   // edge 3: DELAY
        tbl.push_back(mk(0, 0, 3, 2, 0, 0, 0));   // edge 4: RUN
        tbl.push_back(mk(0, 0, 3, 2, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4, 2, 0, 2, 2));
        tbl.push_back(mk(1, 0, 5, 2, 0, 3, 3));   // start ignored in RUN
        tbl.push_back(mk(0, 0, 6, 2, 0, 4, 4));
        tbl.push_back(mk(0, 0, 7, 2, 0, 5, 5));
        tbl.push_back(mk(0, 0, 0, 3, 1, 6, 5));   // 6th RUN cycle halts, zero cause
        tbl.push_back(mk(0, 1, 0, 3, 1, 6, 5));   // stop ignored in HALT
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));   // restart clears counters and cause
        tbl.push_back(mk(0, 0, 8, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 2, 0, 1, 1));

        #1;
        do_reset();

        for (int k = 0; k < tbl.size(); k++) begin
            tick(tbl[k].s, tbl[k].p, tbl[k].iv);
            expect_u(0, $sformatf("tbl%0d", k), tbl[k].est, tbl[k].ecause,
                     tbl[k].ecyc, tbl[k].eins);
        end

        // Reset mid-RUN, then zero instructions from the first RUN cycle.
        do_reset();
        tick(1, 0, 0);
        expect_u(0, "z0", 1, 0, 0, 0);
        tick(0, 0, 0);
        expect_u(0, "z0", 2, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(0, 0, 0);
            expect_u(0, $sformatf("z0c%0d", k), 2, 0, k, 0);
        end
        tick(0, 0, 0);
        expect_u(0, "z0c4", 3, 1, 4, 0);

        // ZERO_RUN=3: pattern 0,0,5,0,0,0 after arming halts only on the last.
        do_reset();
        tick(1, 0, 5);
        tick(0, 0, 5);
        for (int k = 0; k < 3; k++) tick(0, 0, 5);
        pat = '{0, 0, 5, 0, 0, 0};
        for (int j = 0; j < 6; j++) begin
            tick(0, 0, pat[j]);
            if (j < 5) expect_u(1, $sformatf("zr3p%0d", j), 2, 0, 4 + j, -1);
            else       expect_u(1, "zr3p5", 3, 1, 9, 4);
        end

        // TIMEOUT=10 with nonzero instructions.
        do_reset();
        tick(1, 0, 9);
        tick(0, 0, 9);
        for (int k = 1; k <= 10; k++) begin
            tick(0, 0, 9);
            if (k < 10) expect_u(2, $sformatf("tmo%0d", k), 2, 0, k, k);
            else        expect_u(2, "tmo10", 3, 2, 10, 10);
        end
        // Restart from HALT, then stop and a zero instruction together.
        tick(1, 0, 9);
        expect_u(2, "rst_halt", 1, 0, 0, 0);
        tick(0, 0, 9);
        expect_u(2, "rst_halt", 2, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick(0, 0, 9);
        tick(0, 1, 0);
        expect_u(2, "stopzero", 3, 3, 5, 4);
        expect_u(0, "stopzero", 3, 3, -1, -1);

        // Narrow counters saturate; START_DLY=0 enters RUN at the start edge.
        do_reset();
        tick(1, 0, 5);
        expect_u(3, "sat_start", 2, 0, 0, 0);
        for (int k = 0; k < 20; k++) tick(0, 0, 5);
        expect_u(3, "sat", 2, 0, 15, 15);
        tick(0, 0, 32'h100);                      // low byte zero for the 8-bit core
        expect_u(3, "sat_z1", 2, 0, 15, 15);
        tick(0, 0, 0);
        expect_u(3, "sat_z2", 3, 1, 15, 15);

        // Stop during DELAY.
        do_reset();
        tick(1, 0, 1);
        expect_u(0, "dstop", 1, 0, 0, 0);
        tick(0, 1, 1);
        expect_u(0, "dstop", 3, 3, 0, 0);

        // Random traffic checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick(($urandom % 6) == 0, ($urandom % 40) == 0,
                     ($urandom % 3 == 0) ? 32'd0 : 32'($urandom));
            end
        end

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
